cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter data_width, default 16, width of the broadcast result data.
REQ-002 Parameter tag_width, default 3, width of the reservation-station/ROB tag.
REQ-003 Parameter num_src, default 4, number of functional-unit result sources.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  pipeline flush; squashes arbitration in the current cycle.
REQ-007 req  input  num_src  per-source result-ready request (a station's done AND busy).
REQ-008 tag_in  input  num_src x tag_width  per-source destination tag.
REQ-009 data_in  input  num_src x data_width  per-source result data.
REQ-010 grant  output  num_src  one-hot combinational grant back to sources (source frees itself on grant).
REQ-011 CDB_out  output  CDB struct (valid, tag, data)  registered common-data-bus broadcast to all reservation stations and the ROB.

Function
REQ-012 grant SHALL be zero or one-hot, never multi-hot.
REQ-013 grant[i] SHALL be asserted only when req[i]=1, flush=0 and reset=0.
REQ-014 Arbitration SHALL be round-robin: search starts at pointer rr_ptr and proceeds rr_ptr, rr_ptr+1, ... modulo num_src; the first requesting source is granted.
REQ-015 On a grant to source i, rr_ptr SHALL become (i+1) mod num_src at the next edge; wrap from num_src-1 to 0 included.
REQ-016 With no grant (no req, or flush), rr_ptr SHALL hold its value.
REQ-017 On a grant to source i in cycle N, CDB_out SHALL present valid=1, tag=tag_in[i], data=data_in[i] as sampled in cycle N, during cycle N+1 (latency one cycle).
REQ-018 In any cycle with no grant, CDB_out.valid SHALL be 0 at the next edge; tag and data SHALL hold their previous values.
REQ-019 CDB_out.valid SHALL be high for exactly one cycle per grant; back-to-back grants SHALL produce back-to-back valid cycles (one broadcast per cycle throughput).
REQ-020 An ungranted source SHALL keep req asserted with stable tag/data until granted; the arbiter stores no per-source state besides rr_ptr.
REQ-021 With all num_src sources requesting continuously, each source SHALL be granted exactly once in every num_src consecutive cycles (no starvation).
REQ-022 flush=1 SHALL force grant=0 in that cycle and CDB_out.valid=0 in the next cycle, regardless of req; a broadcast already on CDB_out in the flush cycle SHALL complete unchanged.
REQ-023 A request that rises in the same cycle the pointer passes it SHALL be arbitrated by the updated pointer in the following cycle only; no combinational path from CDB_out to grant.

Reset
REQ-024 On reset=1 at a rising edge: rr_ptr=0, CDB_out.valid=0, CDB_out.tag=0, CDB_out.data=0.
REQ-025 grant SHALL be 0 while reset=1.
REQ-026 reset SHALL take priority over flush and over any pending request; a grant issued in the cycle before reset SHALL have its broadcast dropped if reset is high at the broadcast edge.
REQ-027 First arbitration after reset release SHALL start from source 0.

Verification
REQ-028 After reset, req=4'b0100, tag_in[2]=3'd5, data_in[2]=16'hBEEF -> grant=4'b0100 same cycle; next cycle CDB_out={1,5,16'hBEEF}; rr_ptr=3.
REQ-029 req=4'b1111 held 8 cycles from rr_ptr=0 -> grants 0,1,2,3,0,1,2,3 one-hot; CDB_out.valid high 8 consecutive cycles with matching tags.
REQ-030 rr_ptr=3, req=4'b1001 -> grant=4'b1000; next cycle rr_ptr=0 and (req=4'b1001 held) grant=4'b0001 (wrap-around).
REQ-031 req=4'b0010 with flush=1 -> grant=0, next-cycle CDB_out.valid=0, rr_ptr unchanged; flush drops, req held -> grant=4'b0010.
REQ-032 Grant to source 1 in cycle N, reset=1 in cycle N+1 -> CDB_out.valid=0, tag=0, data=0 after that edge; rr_ptr=0.
REQ-033 req=0 for 5 cycles after a broadcast of tag 3/data 16'h1234 -> valid=0 each cycle, tag stays 3, data stays 16'h1234, rr_ptr unchanged.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- round-robin arbiter for the common data bus (CDB).
//
// Functional units raise req when a result is ready. Each cycle one request
// is granted. The search starts at rr_ptr and wraps modulo num_src. The
// winner's tag and data are registered onto the CDB one cycle later.
//
// Parameters
//   data_width  width of the broadcast result data
//   tag_width   width of the reservation-station / ROB tag
//   num_src     number of functional-unit result sources
//
// Ports
//   clk      clock; all state changes on the rising edge
//   reset    synchronous, active-high reset
//   flush    squashes arbitration in the current cycle
//   req      per-source result-ready request
//   tag_in   per-source destination tag
//   data_in  per-source result data
//   grant    one-hot (or zero) combinational grant back to the sources
//   CDB_out  registered broadcast, packed as {valid, tag, data}:
//              CDB_out[data_width+tag_width]                 valid
//              CDB_out[data_width+tag_width-1 : data_width]  tag
//              CDB_out[data_width-1 : 0]                     data
module cdb_arbiter #(
    parameter int data_width = 16,
    parameter int tag_width  = 3,
    parameter int num_src    = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic [num_src-1:0]                    req,
    input  logic [num_src-1:0][tag_width-1:0]     tag_in,
    input  logic [num_src-1:0][data_width-1:0]    data_in,
    output logic [num_src-1:0]                    grant,
    output logic [data_width+tag_width:0]         CDB_out
);

    localparam int PTR_W = (num_src > 1) ? $clog2(num_src) : 1;

    // Advance a source index by one, wrapping from num_src-1 back to 0.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
        if (i == PTR_W'(num_src - 1))
            return '0;
        else
            return i + 1'b1;
    endfunction

    logic [PTR_W-1:0]      rr_ptr;
    logic                  vld_p0;
    logic [PTR_W-1:0]      gidx_p0;
    logic                  vld_p1;
    logic [tag_width-1:0]  tag_p1;
    logic [data_width-1:0] data_p1;

    // Stage p0: combinational round-robin pick. The search starts at rr_ptr.
    // The search uses only registered state and the current inputs, so there
    // is no path from CDB_out back to grant.
    always_comb begin
        int               t;
        logic [PTR_W-1:0] idx;
        grant   = '0;
        vld_p0  = 1'b0;
        gidx_p0 = '0;
        t       = 0;
        idx     = '0;
        if (!reset && !flush) begin
            for (int k = 0; k < num_src; k++) begin
                t = int'(rr_ptr) + k;
                if (t >= num_src)
                    t = t - num_src;
                idx = PTR_W'(t);
                if (!vld_p0 && req[idx]) begin
                    vld_p0     = 1'b1;
                    gidx_p0    = idx;
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    // Stage p1: register the winner onto the CDB. With no winner, valid
    // drops and tag/data keep their last broadcast values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            vld_p1  <= 1'b0;
            tag_p1  <= '0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                tag_p1  <= tag_in[gidx_p0];
                data_p1 <= data_in[gidx_p0];
                rr_ptr  <= wrap_inc(gidx_p0);
            end
        end
    end

    assign CDB_out = {vld_p1, tag_p1, data_p1};

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter.
// Each vector carries a hand-computed expected grant. The expected CDB
// contents for the following cycle go into a queue. A monitor pops and
// compares one entry after each rising edge.
module tb_cdb_arbiter;

    localparam int DW = 16;
    localparam int TW = 3;
    localparam int NS = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   flush;
    logic [NS-1:0]          req;
    logic [NS-1:0][TW-1:0]  tag_in;
    logic [NS-1:0][DW-1:0]  data_in;
    logic [NS-1:0]          grant;
    logic [DW+TW:0]         CDB_out;

    int n_vec  = 0;
    int n_fail = 0;

    logic [DW+TW:0] exp_q[$];
    logic [TW-1:0]  hold_tag;
    logic [DW-1:0]  hold_data;

    cdb_arbiter #(.data_width(DW), .tag_width(TW), .num_src(NS)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .req     (req),
        .tag_in  (tag_in),
        .data_in (data_in),
        .grant   (grant),
        .CDB_out (CDB_out)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus and check the combinational grant.
    // Queue the CDB value expected after the next rising edge.
    task automatic vec(input string name, input logic r, input logic f,
                       input logic [NS-1:0] rq, input logic [NS-1:0] eg);
        logic [DW+TW:0] e;
        @(posedge clk);
        #1;
        reset = r;
        flush = f;
        req   = rq;
        @(negedge clk);
        n_vec++;
        if (grant !== eg) begin
            n_fail++;
            $display("FAIL %s grant: got %b expected %b", name, grant, eg);
        end
        if (r) begin
            hold_tag  = '0;
            hold_data = '0;
            e = '0;
        end else if (eg != '0) begin
            for (int i = 0; i < NS; i++)
                if (eg[i]) begin
                    hold_tag  = tag_in[i];
                    hold_data = data_in[i];
                end
            e = {1'b1, hold_tag, hold_data};
        end else begin
            e = {1'b0, hold_tag, hold_data};
        end
        exp_q.push_back(e);
    endtask

    // Monitor: the CDB register updates on the rising edge, so sample
    // shortly after it.
    initial begin
        logic [DW+TW:0] e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (CDB_out !== e) begin
                    n_fail++;
                    $display("FAIL cdb_out: got v=%b t=%0d d=%h expected v=%b t=%0d d=%h",
                             CDB_out[DW+TW], CDB_out[DW+TW-1:DW], CDB_out[DW-1:0],
                             e[DW+TW], e[DW+TW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        req     = '0;
        tag_in[0] = 3'd1; data_in[0] = 16'h1111;
        tag_in[1] = 3'd2; data_in[1] = 16'h2222;
        tag_in[2] = 3'd5; data_in[2] = 16'hBEEF;
        tag_in[3] = 3'd3; data_in[3] = 16'h1234;

        // Reset beats pending requests and flush.
        vec("rst_req",    1, 0, 4'b1111, 4'b0000);
        vec("rst_flush",  1, 1, 4'b1111, 4'b0000);
        // Single request for source 2: the pointer moves to 3.
        vec("single_s2",  0, 0, 4'b0100, 4'b0100);
        // Wrap-around: pointer at 3 picks 3, then 0.
        vec("wrap_s3",    0, 0, 4'b1001, 4'b1000);
        vec("wrap_s0",    0, 0, 4'b1001, 4'b0001);
        // Flush squashes the grant. The pointer holds at 1 and the src0
        // broadcast already in flight still completes.
        vec("flush",      0, 1, 4'b0010, 4'b0000);
        vec("post_flush", 0, 0, 4'b0010, 4'b0010);
        // Broadcast tag 3 / 16'h1234, then idle: tag and data hold.
        vec("bcast_s3",   0, 0, 4'b1000, 4'b1000);
        for (int i = 0; i < 5; i++)
            vec("idle",   0, 0, 4'b0000, 4'b0000);
        // All sources request from pointer 0: strict rotation.
        vec("rr0",        0, 0, 4'b1111, 4'b0001);
        vec("rr1",        0, 0, 4'b1111, 4'b0010);
        vec("rr2",        0, 0, 4'b1111, 4'b0100);
        vec("rr3",        0, 0, 4'b1111, 4'b1000);
        vec("rr4",        0, 0, 4'b1111, 4'b0001);
        vec("rr5",        0, 0, 4'b1111, 4'b0010);
        vec("rr6",        0, 0, 4'b1111, 4'b0100);
        vec("rr7",        0, 0, 4'b1111, 4'b1000);
        // Grant to source 1, then reset drops its broadcast.
        vec("pre_rst",    0, 0, 4'b0010, 4'b0010);
        vec("rst_drop",   1, 0, 4'b1111, 4'b0000);
        // After release the search starts at source 0, so 1 beats 3.
        vec("after_rst",  0, 0, 4'b1010, 4'b0010);
        vec("next_s3",    0, 0, 4'b1010, 4'b1000);
        // Flush under full load holds the pointer at 0.
        vec("flush_all",  0, 1, 4'b1111, 4'b0000);
        vec("resume",     0, 0, 4'b1111, 4'b0001);
        // Change source data while idle, then broadcast it.
        data_in[2] = 16'hA5C3;
        vec("new_data",   0, 0, 4'b0100, 4'b0100);
        vec("tail_idle",  0, 0, 4'b0000, 4'b0000);

        // Let the monitor drain the queue. Treat a stall as a failure.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
